// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the sysid boot-time integrity checker.
package sysid_check_pkg;

    localparam int DATA_W = 32;
    localparam int ID_OFS = 0;
    localparam int TS_OFS = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID_REQ  = 3'd1,
        ID_WAIT = 3'd2,
        TS_REQ  = 3'd3,
        TS_WAIT = 3'd4,
        CHECK   = 3'd5,
        FINISH  = 3'd6
    } state_t;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Per-read cycle counter: load clears it, enable advances it, expired flags the limit.
module sysid_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_reg;

    // Saturates at the limit so a stuck FSM can never wrap back to "not expired".
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them
// against build-time constants, exporting sticky status flags.
module sysid_checker
    import sysid_check_pkg::*;
#(
    parameter int                unsigned ADDR_W         = 1,
    parameter int                unsigned BASE_ADDR      = 0,
    parameter logic [DATA_W-1:0]          EXPECTED_ID    = 32'd0,
    parameter logic [DATA_W-1:0]          EXPECTED_TS    = 32'd1713458669,
    parameter int                         TIMEOUT_CYCLES = 256,
    parameter bit                         AUTO_START     = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              id_ok,
    output logic              ts_ok,
    output logic              timeout,
    output logic [DATA_W-1:0] id_value,
    output logic [DATA_W-1:0] ts_value
);

    localparam logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(BASE_ADDR + ID_OFS);
    localparam logic [ADDR_W-1:0] TS_ADDR = ADDR_W'(BASE_ADDR + TS_OFS);

    state_t state_reg;
    state_t state_next;
    logic   auto_pending_reg;
    logic   expired;
    logic   ctr_load;
    logic   ctr_enable;
    logic   launch;
    logic   cap_id;
    logic   cap_ts;
    logic   abort;
    logic   do_check;
    logic   do_finish;

    sysid_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clock  (clock),
        .reset_n(reset_n),
        .load   (ctr_load),
        .enable (ctr_enable),
        .expired(expired)
    );

    // Auto-start request lives only for the first clock after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_pending_reg <= AUTO_START;
        end else begin
            auto_pending_reg <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start || auto_pending_reg) state_next = ID_REQ;
            ID_REQ:  if (expired) state_next = IDLE;
                     else if (!avm_waitrequest) state_next = ID_WAIT;
            ID_WAIT: if (expired) state_next = IDLE;
                     else if (avm_readdatavalid) state_next = TS_REQ;
            TS_REQ:  if (expired) state_next = IDLE;
                     else if (!avm_waitrequest) state_next = TS_WAIT;
            TS_WAIT: if (expired) state_next = IDLE;
                     else if (avm_readdatavalid) state_next = CHECK;
            CHECK:   state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        avm_read    = (state_reg == ID_REQ) || (state_reg == TS_REQ);
        avm_address = (state_reg == TS_REQ) ? TS_ADDR : ID_ADDR;
        busy        = (state_reg != IDLE);
        ctr_enable  = (state_reg == ID_REQ) || (state_reg == ID_WAIT) ||
                      (state_reg == TS_REQ) || (state_reg == TS_WAIT);
        // Counter restarts on entry to each request and is parked at zero in IDLE.
        ctr_load    = (state_next != state_reg) &&
                      ((state_next == ID_REQ) || (state_next == TS_REQ) || (state_next == IDLE));
        launch      = (state_reg == IDLE) && (state_next == ID_REQ);
        abort       = ctr_enable && expired;
        cap_id      = (state_reg == ID_WAIT) && avm_readdatavalid && !expired;
        cap_ts      = (state_reg == TS_WAIT) && avm_readdatavalid && !expired;
        do_check    = (state_reg == CHECK);
        do_finish   = (state_reg == FINISH);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done     <= 1'b0;
            pass     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            if (launch) begin
                done    <= 1'b0;
                pass    <= 1'b0;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if (cap_id) id_value <= avm_readdata;
            if (cap_ts) ts_value <= avm_readdata;
            if (do_check) begin
                id_ok <= (id_value == EXPECTED_ID);
                ts_ok <= (ts_value == EXPECTED_TS);
                pass  <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
            end
            if (do_finish) done <= 1'b1;
            if (abort) begin
                timeout <= 1'b1;
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker with a small Avalon-MM slave model.
module tb_sysid_checker;

    localparam logic [31:0] TS_WORD = 32'd1713458669;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [0:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    int          total = 0;
    int          bad = 0;
    int          stall = 0;
    logic        no_rsp = 1'b0;
    logic        late_rdv = 1'b0;
    logic [31:0] id_word = 32'd0;
    logic [31:0] rdata_q = 32'd0;
    logic        rdv_q = 1'b0;
    int          stall_cnt = 0;

    always #5 clock = ~clock;

    sysid_checker #(
        .ADDR_W        (1),
        .BASE_ADDR     (0),
        .EXPECTED_ID   (32'd0),
        .EXPECTED_TS   (TS_WORD),
        .TIMEOUT_CYCLES(16),
        .AUTO_START    (1'b1)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .id_ok            (id_ok),
        .ts_ok            (ts_ok),
        .timeout          (timeout),
        .id_value         (id_value),
        .ts_value         (ts_value)
    );

    // Slave: stalls each request for `stall` cycles, returns data one cycle after acceptance.
    assign avm_waitrequest   = avm_read && (stall_cnt < stall);
    assign avm_readdatavalid = rdv_q | late_rdv;
    assign avm_readdata      = rdata_q;

    always @(posedge clock) begin
        if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
        rdv_q <= avm_read && !avm_waitrequest && !no_rsp;
        if (avm_read && !avm_waitrequest)
            rdata_q <= (avm_address == 1'b0) ? id_word : TS_WORD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            n++;
            if (done) break;
        end
    endtask

    initial begin
        int n;
        logic stable;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_timeout", timeout, 0);
        check("rst_id_value", id_value, 0);

        // Auto-start after reset release
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("auto_busy", busy, 1);
        check("auto_read", avm_read, 1);
        repeat (7) @(posedge clock);
        #1;
        check("auto_done", done, 1);
        check("auto_pass", pass, 1);
        check("auto_id_ok", id_ok, 1);
        check("auto_ts_ok", ts_ok, 1);
        check("auto_busy_low", busy, 0);
        check("auto_id_value", id_value, 0);
        check("auto_ts_value", ts_value, TS_WORD);
        $display("txn auto-start: done=%0d pass=%0d", done, pass);

        // Wrong ID word
        id_word = 32'h12345678;
        pulse_start();
        wait_done(n);
        check("badid_latency", n, 6);
        check("badid_id_ok", id_ok, 0);
        check("badid_ts_ok", ts_ok, 1);
        check("badid_pass", pass, 0);
        check("badid_done", done, 1);
        check("badid_id_value", id_value, 32'h12345678);
        $display("txn bad-id: id_value=%08h pass=%0d", id_value, pass);

        // Five-cycle waitrequest stall on each read
        id_word = 32'd0;
        stall = 5;
        pulse_start();
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(avm_read && avm_waitrequest && avm_address == 1'b0)) stable = 1'b0;
            @(posedge clock);
            #1;
        end
        wait_done(n);
        check("stall_stable", stable, 1);
        check("stall_latency", 5 + n, 16);
        check("stall_pass", pass, 1);
        $display("txn stall: latency=%0d pass=%0d", 5 + n, pass);

        // Slave never returns data
        stall = 0;
        no_rsp = 1'b1;
        id_word = 32'hDEADBEEF;
        pulse_start();
        wait_done(n);
        check("to_latency", n, 17);
        check("to_timeout", timeout, 1);
        check("to_done", done, 1);
        check("to_pass", pass, 0);
        check("to_read", avm_read, 0);
        check("to_busy", busy, 0);
        @(negedge clock) late_rdv = 1'b1;
        @(negedge clock) late_rdv = 1'b0;
        @(posedge clock);
        #1;
        check("late_id_value", id_value, 0);
        check("late_ts_value", ts_value, TS_WORD);
        check("late_busy", busy, 0);
        $display("txn timeout: timeout=%0d ts_value=%08h", timeout, ts_value);

        // start while busy is ignored; start after done reruns
        no_rsp = 1'b0;
        id_word = 32'd0;
        pulse_start();
        check("rerun_timeout_clr", timeout, 0);
        @(posedge clock);
        #1;
        pulse_start();
        wait_done(n);
        check("midstart_latency", n, 4);
        check("midstart_pass", pass, 1);
        pulse_start();
        check("launch_done_clr", done, 0);
        check("launch_pass_clr", pass, 0);
        wait_done(n);
        check("rerun_latency", n, 6);
        check("rerun_pass", pass, 1);
        $display("txn restart: pass=%0d", pass);

        // start coinciding with FINISH is ignored
        pulse_start();
        repeat (5) @(posedge clock);
        #1;
        check("finish_busy", busy, 1);
        pulse_start();
        check("finish_done", done, 1);
        check("finish_idle", busy, 0);
        @(posedge clock);
        #1;
        check("finish_stay_idle", busy, 0);
        $display("txn start-at-finish: busy=%0d", busy);

        // Asynchronous reset during TS_WAIT
        pulse_start();
        repeat (3) @(posedge clock);
        #1;
        check("tsw_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_read", avm_read, 0);
        check("arst_done", done, 0);
        check("arst_ts_value", ts_value, 0);
        @(negedge clock) reset_n = 1'b1;
        wait_done(n);
        check("arst_rerun_latency", n, 7);
        check("arst_rerun_pass", pass, 1);
        check("arst_rerun_ts", ts_value, TS_WORD);
        $display("txn async-reset: pass=%0d", pass);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
